// File: rtl/can_mem_arbiter.sv
// can_mem_arbiter: shares the single-port CAN message memory between the CAN core
// and the host, with a host starvation guard and a sequenced whole-memory clear.
module can_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int MAX_HOLD   = 4,
  parameter int CLR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_rw,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_din,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_dout,
  input  logic              h_req,
  input  logic              h_rw,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_din,
  output logic              h_ack,
  output logic [DATA_W-1:0] h_dout,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              mem_rst_n,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [2:0] {IDLE, ACCESS, RWAIT, ACK, CLEAR} state_t;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);
  localparam logic [3:0] CLR_LAST   = 4'(CLR_CYCLES - 1);

  state_t             state;
  state_t             next_state;
  logic               gnt_c;
  logic               gnt_h;
  logic               gnt_any;
  logic               clr_done;
  logic               host_owner;
  logic               is_read;
  logic               clr_pend;
  logic [3:0]         streak;
  logic [3:0]         clr_cnt;
  logic               sel_rw;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_din;

  // Grants are only decided in IDLE; a pending clear outranks both requesters.
  always_comb begin
    next_state = state;
    gnt_c      = 1'b0;
    gnt_h      = 1'b0;
    clr_done   = 1'b0;
    case (state)
      IDLE: begin
        if (clr_pend) begin
          next_state = CLEAR;
        end else if (c_req && !(h_req && streak == HOLD_LIMIT)) begin
          gnt_c      = 1'b1;
          next_state = ACCESS;
        end else if (h_req) begin
          gnt_h      = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: next_state = is_read ? RWAIT : ACK;
      RWAIT:  next_state = ACK;
      ACK:    next_state = IDLE;
      CLEAR: begin
        if (clr_cnt == CLR_LAST) begin
          clr_done   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign gnt_any  = gnt_c | gnt_h;
  assign sel_rw   = gnt_h ? h_rw   : c_rw;
  assign sel_addr = gnt_h ? h_addr : c_addr;
  assign sel_din  = gnt_h ? h_din  : c_din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // mem_rst_n is registered low in reset so the memory is also wiped by system reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_owner <= 1'b0;
      is_read    <= 1'b0;
      mem_rw     <= 1'b1;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_rst_n  <= 1'b0;
    end else begin
      mem_rw    <= gnt_any ? sel_rw : 1'b1;
      mem_rst_n <= (next_state != CLEAR);
      if (gnt_any) begin
        host_owner <= gnt_h;
        is_read    <= sel_rw;
        mem_addr   <= sel_addr;
        mem_din    <= sel_din;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (gnt_h) begin
      streak <= '0;
    end else if (gnt_c) begin
      streak <= h_req ? streak + 4'd1 : 4'd0;
    end
  end

  // A clear request arriving while one is pending or running is simply absorbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_pend <= 1'b0;
      clr_cnt  <= '0;
    end else begin
      clr_pend <= clr_done ? 1'b0 : (clr_pend | clr_req);
      clr_cnt  <= (state == CLEAR) ? clr_cnt + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_dout <= '0;
      h_dout <= '0;
    end else if (state == RWAIT) begin
      if (host_owner) begin
        h_dout <= mem_dout;
      end else begin
        c_dout <= mem_dout;
      end
    end
  end

  assign c_ack    = (state == ACK) && !host_owner;
  assign h_ack    = (state == ACK) &&  host_owner;
  assign clr_busy = clr_pend;

endmodule

// File: tb/tb_can_mem_arbiter.sv
// tb_can_mem_arbiter: drives both masters against a behavioural 256x8 memory and
// checks acks, read data, latency, arbitration order and clear sequencing.
module tb_can_mem_arbiter;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int MAX_HOLD   = 4;
  localparam int CLR_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       c_req, c_rw, h_req, h_rw;
  logic [7:0] c_addr, c_din, h_addr, h_din;
  logic       c_ack, h_ack;
  logic [7:0] c_dout, h_dout;
  logic       clr_req, clr_busy;
  logic       mem_rst_n, mem_rw;
  logic [7:0] mem_addr, mem_din, mem_dout;

  logic [7:0] mem_arr [256];
  logic [7:0] ref_mem [256];
  int         m_streak = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    bit         host;
    bit         rd;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] exp_dout;
    int         exp_cycles;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  can_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD), .CLR_CYCLES(CLR_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_rw(c_rw), .c_addr(c_addr), .c_din(c_din), .c_ack(c_ack), .c_dout(c_dout),
    .h_req(h_req), .h_rw(h_rw), .h_addr(h_addr), .h_din(h_din), .h_ack(h_ack), .h_dout(h_dout),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .mem_rst_n(mem_rst_n), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Synchronous-read memory; rst_n low wipes every location.
  always @(posedge clk) begin
    if (!mem_rst_n) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 8'h00;
    end else if (!mem_rw) begin
      mem_arr[mem_addr] <= mem_din;
    end
    mem_dout <= mem_arr[mem_addr];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  // Issues one request from one master and waits for its ack; called at a negedge.
  task automatic apply_stimulus(input bit host, input bit rd, input logic [7:0] addr,
                                input logic [7:0] din, output logic [7:0] dout,
                                output int cycles, output bit acked, output bit stray,
                                output bit busy_at_ack);
    acked = 0; stray = 0; cycles = 1; dout = 8'h00; busy_at_ack = 0;
    if (host) begin
      h_req = 1; h_rw = rd; h_addr = addr; h_din = din;
    end else begin
      c_req = 1; c_rw = rd; c_addr = addr; c_din = din;
    end
    for (int k = 0; k < 40 && !acked; k++) begin
      @(posedge clk); @(negedge clk);
      cycles++;
      if (host ? c_ack : h_ack) stray = 1;
      if (host ? h_ack : c_ack) begin
        acked = 1;
        dout = host ? h_dout : c_dout;
        busy_at_ack = clr_busy;
        c_req = 0; h_req = 0;
      end
    end
    c_req = 0; h_req = 0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic run_txn(input string name, input bit host, input bit rd, input logic [7:0] addr,
                         input logic [7:0] din, input logic [7:0] exp_dout, input int exp_cycles);
    logic [7:0] dout, prev;
    int cyc;
    bit acked, stray, busy;
    prev = host ? h_dout : c_dout;
    apply_stimulus(host, rd, addr, din, dout, cyc, acked, stray, busy);
    check_output({name, "_ack"}, acked, 1);
    check_output({name, "_stray_ack"}, stray, 0);
    check_output({name, "_cycles"}, cyc, exp_cycles);
    if (rd) check_output({name, "_dout"}, dout, exp_dout);
    else    check_output({name, "_dout_hold"}, dout, prev);
    if (!rd) ref_mem[addr] = din;
    m_streak = 0;
  endtask

  // Both masters request in the same IDLE cycle; the model picks the order.
  task automatic run_both(input string name, input bit c_rd, input logic [7:0] c_a, input logic [7:0] c_d,
                          input bit h_rd, input logic [7:0] h_a, input logic [7:0] h_d);
    bit host_first_exp, host_first, c_done, h_done;
    int cyc, c_cyc, h_cyc, c_len, h_len;
    logic [7:0] c_exp, h_exp, c_got, h_got;
    c_len = c_rd ? 4 : 3;
    h_len = h_rd ? 4 : 3;
    host_first_exp = (m_streak == MAX_HOLD);
    if (host_first_exp) begin
      h_exp = ref_mem[h_a]; if (!h_rd) ref_mem[h_a] = h_d;
      c_exp = ref_mem[c_a]; if (!c_rd) ref_mem[c_a] = c_d;
    end else begin
      c_exp = ref_mem[c_a]; if (!c_rd) ref_mem[c_a] = c_d;
      h_exp = ref_mem[h_a]; if (!h_rd) ref_mem[h_a] = h_d;
    end
    m_streak = 0;
    c_req = 1; c_rw = c_rd; c_addr = c_a; c_din = c_d;
    h_req = 1; h_rw = h_rd; h_addr = h_a; h_din = h_d;
    c_done = 0; h_done = 0; host_first = 0; cyc = 1; c_cyc = 0; h_cyc = 0;
    c_got = 8'h00; h_got = 8'h00;
    for (int k = 0; k < 60 && !(c_done && h_done); k++) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (c_ack && !c_done) begin c_done = 1; c_cyc = cyc; c_got = c_dout; c_req = 0; end
      if (h_ack && !h_done) begin
        h_done = 1; h_cyc = cyc; h_got = h_dout; h_req = 0;
        if (!c_done) host_first = 1;
      end
    end
    c_req = 0; h_req = 0;
    @(posedge clk); @(negedge clk);
    check_output({name, "_both_acked"}, c_done && h_done, 1);
    check_output({name, "_host_first"}, host_first, host_first_exp);
    check_output({name, "_c_cycles"}, c_cyc, host_first_exp ? h_len + c_len : c_len);
    check_output({name, "_h_cycles"}, h_cyc, host_first_exp ? h_len : c_len + h_len);
    if (c_rd) check_output({name, "_c_dout"}, c_got, c_exp);
    if (h_rd) check_output({name, "_h_dout"}, h_got, h_exp);
  endtask

  initial begin
    logic [7:0] dout;
    int cyc, n, lows, acks_seen;
    bit acked, stray, busy, seen_low, done_clr;
    bit got [10];

    rst = 1; clr_req = 0;
    c_req = 0; c_rw = 1; c_addr = 0; c_din = 0;
    h_req = 0; h_rw = 1; h_addr = 0; h_din = 0;
    ref_clear();

    vecs[0] = '{0, 0, 8'h55, 8'h55, 8'h00, 3};
    vecs[1] = '{1, 1, 8'h55, 8'h00, 8'h55, 4};
    vecs[2] = '{1, 0, 8'h01, 8'hA5, 8'h00, 3};
    vecs[3] = '{0, 1, 8'h01, 8'h00, 8'hA5, 4};
    vecs[4] = '{0, 1, 8'h02, 8'h00, 8'h00, 4};
    vecs[5] = '{1, 0, 8'hFF, 8'hFF, 8'h00, 3};
    vecs[6] = '{0, 1, 8'hFF, 8'h00, 8'hFF, 4};
    vecs[7] = '{1, 1, 8'h00, 8'h00, 8'h00, 4};

    repeat (3) @(negedge clk);
    check_output("rst_c_ack", c_ack, 0);
    check_output("rst_h_ack", h_ack, 0);
    check_output("rst_c_dout", c_dout, 0);
    check_output("rst_h_dout", h_dout, 0);
    check_output("rst_clr_busy", clr_busy, 0);
    check_output("rst_mem_rw", mem_rw, 1);
    check_output("rst_mem_addr", mem_addr, 0);
    check_output("rst_mem_din", mem_din, 0);
    check_output("rst_mem_rst_n", mem_rst_n, 0);
    rst = 0;
    #1 check_output("rst_mem_rst_n_hold", mem_rst_n, 0);
    @(negedge clk);
    check_output("rst_mem_rst_n_rise", mem_rst_n, 1);

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].host, vecs[i].rd, vecs[i].addr,
              vecs[i].din, vecs[i].exp_dout, vecs[i].exp_cycles);
    end

    // Continuous contention: the host must get every (MAX_HOLD+1)th grant.
    run_txn("pre_c", 0, 0, 8'h10, 8'h11, 8'h00, 3);
    run_txn("pre_h", 1, 0, 8'h20, 8'h22, 8'h00, 3);
    c_req = 1; c_rw = 1; c_addr = 8'h10;
    h_req = 1; h_rw = 1; h_addr = 8'h20;
    n = 0;
    for (int k = 0; k < 120 && n < 10; k++) begin
      @(posedge clk); @(negedge clk);
      if (c_ack) begin
        got[n] = 0; check_output($sformatf("cont%0d_c_dout", n), c_dout, 8'h11); n++;
      end else if (h_ack) begin
        got[n] = 1; check_output($sformatf("cont%0d_h_dout", n), h_dout, 8'h22); n++;
      end
      if (n == 10) begin c_req = 0; h_req = 0; end
    end
    c_req = 0; h_req = 0;
    @(posedge clk); @(negedge clk);
    check_output("cont_count", n, 10);
    for (int i = 0; i < 10; i++) begin
      bit exp_h;
      exp_h = (m_streak == MAX_HOLD);
      m_streak = exp_h ? 0 : m_streak + 1;
      check_output($sformatf("cont%0d_order", i), got[i], exp_h);
    end

    // Clear raised while a host read is in flight.
    run_txn("clr_pre", 0, 0, 8'hAA, 8'hAA, 8'h00, 3);
    h_req = 1; h_rw = 1; h_addr = 8'hAA;
    @(posedge clk); @(negedge clk);
    check_output("clr_access_rw", mem_rw, 1);
    clr_req = 1;
    @(posedge clk); @(negedge clk);
    clr_req = 0;
    check_output("clr_busy_set", clr_busy, 1);
    @(posedge clk); @(negedge clk);
    check_output("clr_read_ack", h_ack, 1);
    check_output("clr_read_dout", h_dout, 8'hAA);
    h_req = 0;
    lows = 0; seen_low = 0; done_clr = 0;
    for (int k = 0; k < 20 && !done_clr; k++) begin
      @(posedge clk); @(negedge clk);
      if (!mem_rst_n) begin
        lows++; seen_low = 1;
        check_output("clr_busy_during", clr_busy, 1);
      end else if (seen_low) begin
        done_clr = 1;
        check_output("clr_busy_fall", clr_busy, 0);
      end
    end
    check_output("clr_done", done_clr, 1);
    check_output("clr_low_cycles", lows, CLR_CYCLES);
    ref_clear();
    run_txn("clr_readback", 1, 1, 8'hAA, 8'h00, ref_mem[8'hAA], 4);

    // Host write issued while a clear is running.
    clr_req = 1;
    @(posedge clk); @(negedge clk);
    clr_req = 0;
    check_output("clr2_busy", clr_busy, 1);
    for (int k = 0; k < 10 && mem_rst_n; k++) begin
      @(posedge clk); @(negedge clk);
    end
    check_output("clr2_in_clear", mem_rst_n, 0);
    ref_clear();
    apply_stimulus(1, 0, 8'h10, 8'h3C, dout, cyc, acked, stray, busy);
    check_output("clr2_wr_ack", acked, 1);
    check_output("clr2_wr_busy_at_ack", busy, 0);
    check_output("clr2_wr_cycles", cyc, CLR_CYCLES + 3);
    ref_mem[8'h10] = 8'h3C;
    run_txn("clr2_readback", 1, 1, 8'h10, 8'h00, ref_mem[8'h10], 4);

    // Randomized traffic checked against the reference memory and arbitration model.
    for (int it = 0; it < 40; it++) begin
      int mode;
      bit r1, r2;
      logic [7:0] a1, a2, d1, d2;
      mode = $urandom_range(0, 2);
      r1 = 1'($urandom); r2 = 1'($urandom);
      a1 = 8'($urandom_range(0, 15)); a2 = 8'($urandom_range(0, 15));
      d1 = 8'($urandom); d2 = 8'($urandom);
      if (mode == 2) run_both($sformatf("rnd%0d", it), r1, a1, d1, r2, a2, d2);
      else run_txn($sformatf("rnd%0d", it), mode == 1, r1, a1, d1, ref_mem[a1], r1 ? 4 : 3);
    end

    // Reset in the middle of a CAN write.
    c_req = 1; c_rw = 0; c_addr = 8'h20; c_din = 8'h77;
    @(posedge clk); @(negedge clk);
    check_output("abort_access_rw", mem_rw, 0);
    rst = 1;
    #1;
    check_output("abort_mem_rw", mem_rw, 1);
    check_output("abort_c_ack", c_ack, 0);
    check_output("abort_clr_busy", clr_busy, 0);
    check_output("abort_mem_rst_n", mem_rst_n, 0);
    c_req = 0;
    @(negedge clk);
    rst = 0;
    acks_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (c_ack) acks_seen++;
    end
    check_output("abort_no_ack", acks_seen, 0);
    ref_clear();
    m_streak = 0;
    run_txn("abort_readback", 0, 1, 8'h20, 8'h00, ref_mem[8'h20], 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
